// File: rtl/net_strength_checker.sv
// Compares the twelve net-type/strength outputs against the expected vector after a settle
// window and publishes one sticky-mask report per run. Optional 4-state compare: NET_CHECK_XPROP_EN.
module net_strength_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_CHECKS    = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             drive_ref,
    input  logic [11:0]      obs_vec,
    output logic             busy,
    output logic             report_valid,
    input  logic             report_ready,
    output logic             pass,
    output logic [11:0]      fail_mask,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       first_fail_idx
);
    localparam int               CHK_W       = $clog2(NUM_CHECKS + 1);
    localparam logic [CHK_W-1:0] LAST_CHECK  = CHK_W'(NUM_CHECKS - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, REPORT} state_t;

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [CHK_W-1:0] check_cnt;
    logic             prev_ref;
    logic             ref_changed;
    logic [11:0]      expected;
    logic [11:0]      mismatch;
    logic [11:0]      mask_next;
    logic [3:0]       low_idx;

    // Bits [9:0] follow the stimulus; pulldown reads 0 and pullup reads 1 regardless.
    always_comb begin
        expected    = {1'b1, 1'b0, {10{drive_ref}}};
        ref_changed = (drive_ref != prev_ref);
`ifdef NET_CHECK_XPROP_EN
        mismatch = '0;
        for (int i = 0; i < 12; i++) begin
            mismatch[i] = (obs_vec[i] !== expected[i]);
        end
        if ((drive_ref !== 1'b0) && (drive_ref !== 1'b1)) begin
            mismatch = '1;
        end
`else
        mismatch = obs_vec ^ expected;
`endif
        mask_next = fail_mask | mismatch;
        low_idx   = 4'hF;
        for (int i = 11; i >= 0; i--) begin
            if (mismatch[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // A stimulus change restarts the settle window and never consumes a check slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            check_cnt      <= '0;
            prev_ref       <= 1'b0;
            busy           <= 1'b0;
            report_valid   <= 1'b0;
            pass           <= 1'b0;
            fail_mask      <= '0;
            err_count      <= '0;
            first_fail_idx <= 4'hF;
        end else begin
            prev_ref <= drive_ref;
            case (state)
                IDLE: begin
                    if (start) begin
                        fail_mask      <= '0;
                        err_count      <= '0;
                        first_fail_idx <= 4'hF;
                        pass           <= 1'b0;
                        check_cnt      <= '0;
                        settle_cnt     <= SETTLE_LOAD;
                        busy           <= 1'b1;
                        state          <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                    end
                end
                SETTLE: begin
                    if (ref_changed) begin
                        settle_cnt <= SETTLE_LOAD;
                    end else if (settle_cnt <= 4'd1) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (ref_changed) begin
                        if (SETTLE_CYCLES != 0) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end else begin
                        fail_mask <= mask_next;
                        if (|mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (first_fail_idx == 4'hF) begin
                                first_fail_idx <= low_idx;
                            end
                        end
                        check_cnt <= check_cnt + CHK_W'(1);
                        if (check_cnt == LAST_CHECK) begin
                            state        <= REPORT;
                            report_valid <= 1'b1;
                            pass         <= (mask_next == 12'h000);
                        end
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_net_strength_checker.sv
// Scoreboard bench for net_strength_checker: directed runs queue their expected report and
// per-instance monitors pop and compare whenever a report is presented.
module tb_net_strength_checker;

    typedef struct {
        logic        pass_e;
        logic [11:0] mask;
        int          count;
        logic [3:0]  idx;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_sat;
    logic        drive_ref;
    logic        report_ready;
    logic [11:0] obs_vec;

    logic        busy, report_valid, pass;
    logic [11:0] fail_mask;
    logic [7:0]  err_count;
    logic [3:0]  first_fail_idx;

    logic        busy_s, report_valid_s, pass_s;
    logic [11:0] fail_mask_s;
    logic [3:0]  err_count_s;
    logic [3:0]  first_fail_idx_s;

    int   n_checks    = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   start_cycle = 0;
    int   lat_seen    = 0;
    int   lat_seen_s  = 0;
    logic prev_valid  = 1'b0;
    logic prev_valid_s = 1'b0;
    exp_t exp_q[$];
    exp_t exp_sat_q[$];
    exp_t mon_e;
    exp_t mon_e_s;

    net_strength_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .drive_ref(drive_ref), .obs_vec(obs_vec),
        .busy(busy), .report_valid(report_valid), .report_ready(report_ready), .pass(pass),
        .fail_mask(fail_mask), .err_count(err_count), .first_fail_idx(first_fail_idx)
    );

    net_strength_checker #(.SETTLE_CYCLES(2), .NUM_CHECKS(20), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat), .drive_ref(drive_ref), .obs_vec(obs_vec),
        .busy(busy_s), .report_valid(report_valid_s), .report_ready(report_ready), .pass(pass_s),
        .fail_mask(fail_mask_s), .err_count(err_count_s), .first_fail_idx(first_fail_idx_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    task automatic checkReport(input string tag, input exp_t e, input logic p, input logic [11:0] m,
                               input int c, input logic [3:0] idx, input int lat, input bit with_lat);
        checkOutput({tag, "_pass"}, p, e.pass_e);
        checkOutput({tag, "_fail_mask"}, m, e.mask);
        checkOutput({tag, "_err_count"}, c, e.count);
        checkOutput({tag, "_first_fail_idx"}, idx, e.idx);
        if (with_lat) checkOutput({tag, "_latency"}, lat, e.lat);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sat, input bit push, input exp_t e,
                                 input logic ref_v, input logic [11:0] obs);
        drive_ref = ref_v;
        obs_vec   = obs;
        if (push) begin
            if (sat) exp_sat_q.push_back(e);
            else     exp_q.push_back(e);
        end
        start_cycle = cyc + 1;
        if (sat) start_sat = 1'b1;
        else     start     = 1'b1;
        tick();
        start     = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic waitDrained(input bit sat, input int budget, input string name);
        int k = 0;
        while (((sat ? exp_sat_q.size() : exp_q.size()) != 0) && (k < budget)) begin
            tick();
            k++;
        end
        if ((sat ? exp_sat_q.size() : exp_q.size()) != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: report still pending after %0d cycles, required none", name, budget);
            if (sat) exp_sat_q.delete();
            else     exp_q.delete();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_report_valid"}, report_valid, 0);
        checkOutput({tag, "_pass"}, pass, 0);
        checkOutput({tag, "_fail_mask"}, fail_mask, 0);
        checkOutput({tag, "_err_count"}, err_count, 0);
        checkOutput({tag, "_first_fail_idx"}, first_fail_idx, 15);
    endtask

    // Monitor for the default instance: holds are checked against the queue head, handshakes pop it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (report_valid && !prev_valid) lat_seen = cyc - start_cycle + 1;
            if (report_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_report: report_valid=1, required no report");
                end else if (!report_ready) begin
                    checkReport("hold", exp_q[0], pass, fail_mask, int'(err_count), first_fail_idx, 0, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkReport("report", mon_e, pass, fail_mask, int'(err_count), first_fail_idx, lat_seen, 1'b1);
                end
            end
            prev_valid = report_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (report_valid_s && !prev_valid_s) lat_seen_s = cyc - start_cycle + 1;
            if (report_valid_s) begin
                if (exp_sat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sat_unexpected_report: report_valid=1, required no report");
                end else if (report_ready) begin
                    mon_e_s = exp_sat_q.pop_front();
                    checkReport("sat", mon_e_s, pass_s, fail_mask_s, int'(err_count_s), first_fail_idx_s, lat_seen_s, 1'b1);
                end
            end
            prev_valid_s = report_valid_s;
        end else begin
            prev_valid_s = 1'b0;
        end
    end

    initial begin
        exp_t e;
        int   k;
        rst_n        = 1'b0;
        start        = 1'b0;
        start_sat    = 1'b0;
        drive_ref    = 1'b1;
        obs_vec      = 12'hBFF;
        report_ready = 1'b1;
        #12;
        checkResetValues("reset");
        checkOutput("reset_sat_busy", busy_s, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Clean run: all nets follow the stimulus.
        e = '{1'b1, 12'h000, 0, 4'hF, 19};
        applyStimulus(1'b0, 1'b1, e, 1'b1, 12'hBFF);
        waitDrained(1'b0, 60, "clean");
        tick();

        // Pulldown net stuck high.
        e = '{1'b0, 12'h400, 16, 4'hA, 19};
        applyStimulus(1'b0, 1'b1, e, 1'b1, 12'hFFF);
        waitDrained(1'b0, 60, "pulldown_stuck");
        tick();

        // Stimulus toggles on the 5th compare; nets follow a cycle later.
        e = '{1'b1, 12'h000, 0, 4'hF, 22};
        applyStimulus(1'b0, 1'b1, e, 1'b1, 12'hBFF);
        repeat (6) tick();
        drive_ref = 1'b0;
        tick();
        obs_vec = 12'h800;
        waitDrained(1'b0, 60, "resettle");
        tick();

        // Narrow counter saturates on a persistently inverted uwire.
        e = '{1'b0, 12'h001, 15, 4'h0, 23};
        applyStimulus(1'b1, 1'b1, e, 1'b1, 12'hBFE);
        waitDrained(1'b1, 80, "saturate");
        tick();
        checkOutput("sat_idle_busy", busy_s, 0);

        // Back-pressured report: holds stable, ignores start, then handshakes to IDLE.
        report_ready = 1'b0;
        e = '{1'b1, 12'h000, 0, 4'hF, 19};
        applyStimulus(1'b0, 1'b1, e, 1'b1, 12'hBFF);
        k = 0;
        while (!report_valid && (k < 40)) begin
            tick();
            k++;
        end
        checkOutput("backpressure_valid_seen", report_valid, 1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
        end
        report_ready = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        waitDrained(1'b0, 5, "backpressure");
        tick();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_report_valid", report_valid, 0);
        checkOutput("idle_pass_held", pass, 1);

        // Asynchronous reset in the middle of a failing run, then a clean rerun.
        applyStimulus(1'b0, 1'b0, e, 1'b1, 12'hFFF);
        repeat (5) tick();
        checkOutput("mid_err_count", err_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        e = '{1'b1, 12'h000, 0, 4'hF, 19};
        applyStimulus(1'b0, 1'b1, e, 1'b1, 12'hBFF);
        waitDrained(1'b0, 60, "post_reset");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/net_strength_checker.md
Name: net_strength_checker

Overview:
- Downstream consumer of the net-type/strength test stage. Samples that stage's twelve net outputs against the stimulus bit that drives it.
- Waits a settle window after every stimulus change, then compares for a fixed number of cycles. Accumulates a sticky per-net fail mask and a saturating error count.
- Publishes one report through a valid/ready handshake, for use by the self-checking harness of the LexerFacts isolated tests.

Parameters:
- SETTLE_CYCLES, 2: cycles to wait after start or after any drive_ref change before comparing; legal range 0..15.
- NUM_CHECKS, 16: number of compared (non-settle) cycles per run; must be >= 1.
- CNT_W, 8: width of err_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a run, honoured only in IDLE.
- drive_ref  input  1  stimulus bit currently driven into the upstream stage.
- obs_vec  input  12 (logic)  observed nets. Bit order: [0] uwire, [1] tri, [2] tri0, [3] tri1, [4] triand, [5] trior, [6] trireg, [7] wand, [8] wor, [9] scalared, [10] pulldown, [11] pullup.
- busy  output  1  high in SETTLE, CHECK and REPORT.
- report_valid  output  1  report available.
- report_ready  input  1  consumer accepts report.
- pass  output  1  fail_mask == 0; valid only while report_valid.
- fail_mask  output  12  sticky per-bit mismatch flags.
- err_count  output  CNT_W  count of mismatching compare cycles, saturating at all-ones.
- first_fail_idx  output  4  lowest mismatching bit index in the first failing cycle; 4'hF if none.

Behaviour:
- Reset (async on rst_n low, including mid-run):
  - State returns to IDLE.
  - busy=0, report_valid=0, pass=0, fail_mask=0, err_count=0, first_fail_idx=4'hF.
  - Internal counters and the drive_ref history register clear to 0.
- Expected vector:
  - Bits [9:0] equal drive_ref.
  - Bit 10 equals 0 (pulldown).
  - Bit 11 equals 1 (pullup).
- States:
  - IDLE: on start, clear fail_mask, err_count and first_fail_idx; load settle counter; go to SETTLE (or straight to CHECK if SETTLE_CYCLES==0). busy rises the cycle after start.
  - SETTLE: decrement the counter each cycle. When it reaches 0, go to CHECK. A drive_ref change reloads the counter.
  - CHECK:
    - Each cycle, drive_ref is compared with its registered value from the previous cycle.
    - If drive_ref changed: no compare that cycle; go to SETTLE with the counter reloaded (or stay in CHECK and skip the compare if SETTLE_CYCLES==0). The check count is not advanced.
    - Otherwise: compare obs_vec with the expected vector.
      - OR the mismatch bits into fail_mask.
      - If any bit mismatches, err_count increments by 1 (saturating).
      - If this is the first failing cycle, latch first_fail_idx.
      - The check count increments.
    - When the check count reaches NUM_CHECKS, go to REPORT.
  - REPORT: report_valid=1. pass, fail_mask, err_count and first_fail_idx are held stable. On report_valid && report_ready: report_valid drops next cycle; go to IDLE. Outputs keep their values until the next start.
- Edge cases and latencies:
  - start outside IDLE is ignored.
  - start coinciding with the report handshake is ignored. A new start is needed in IDLE.
  - Minimum run latency, start to report_valid, with no drive_ref changes: 1 + SETTLE_CYCLES + NUM_CHECKS cycles.
  - The check counter is $clog2(NUM_CHECKS+1) bits wide and never wraps.

Optional Feature:
- Macro: NET_CHECK_XPROP_EN.
- Defined:
  - Per-bit compare uses 4-state case inequality (!==), so X or Z on any obs_vec bit counts as a mismatch.
  - In the same cycle, an X/Z on drive_ref forces all twelve mask bits and counts one error.
- Undefined: 2-state compare (!=); X/Z resolution is left to the simulator. This is the synthesizable default.

Test Plan:
- drive_ref=1 constant, obs_vec=12'b1011_1111_1111, start, SETTLE_CYCLES=2, NUM_CHECKS=16 -> report_valid at cycle 19 after start; pass=1, fail_mask=0, err_count=0, first_fail_idx=4'hF.
- As above with obs_vec bit 10 stuck at 1 -> fail_mask=12'h400, err_count=16, first_fail_idx=10, pass=0.
- Toggle drive_ref at compare cycle 5 with obs_vec following one cycle later -> re-settle inserted, no mismatch counted, report_valid delayed by 3 cycles, pass=1.
- CNT_W=4, NUM_CHECKS=20, obs_vec bit 0 inverted -> err_count saturates at 15, fail_mask=12'h001.
- Hold report_ready=0 for 5 cycles after report_valid -> outputs stable; start pulses ignored; handshake completes, then IDLE.
- Assert rst_n low mid-CHECK with err_count=3 -> all outputs return to reset values immediately (async); a subsequent start runs cleanly.
